// File: rtl/pic_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pic_host_pkg
// Description : Shared FSM states, A0 encodings and ICW1 bit indices for the
//               host-side PIC acknowledge / programming master.
// Revision    : 1.0 - initial release
// ============================================================================
package pic_host_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACK1      = 3'd1,
        GAP       = 3'd2,
        ACK2      = 3'd3,
        HOLD      = 3'd4,
        WR_LO     = 3'd5,
        WR_END    = 3'd6,
        INIT_NEXT = 3'd7
    } pic_state_t;

    localparam logic A0_ICW1_OCW23 = 1'b0;
    localparam logic A0_ICWn_OCW1  = 1'b1;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;

    // Returns {last, next_idx}; index 0..3 maps to ICW1..ICW4.
    function automatic logic [2:0] icw_next(input logic [1:0] idx,
                                            input logic       ic4,
                                            input logic       sngl);
        logic [2:0] r;
        case (idx)
            2'd0:    r = {1'b0, 2'd1};
            2'd1:    r = !sngl ? {1'b0, 2'd2} : (ic4 ? {1'b0, 2'd3} : {1'b1, 2'd0});
            2'd2:    r = ic4 ? {1'b0, 2'd3} : {1'b1, 2'd0};
            default: r = {1'b1, 2'd0};
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pic_inta_master_if.sv
`default_nettype none
// ============================================================================
// Module      : pic_inta_master_if
// Description : PIC bus, host write request and vector handshake signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface pic_inta_master_if;
    logic       int_in;
    logic       int_enable;
    logic       inta_n;
    logic [7:0] data_in;
    logic       cs_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] data_out;
    logic       data_oe;
    logic       wr_req;
    logic       wr_a0;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic [7:0] vector_out;
    logic       vector_valid;
    logic       vector_ready;
    logic       init_start;
    logic [7:0] icw1;
    logic [7:0] icw2;
    logic [7:0] icw3;
    logic [7:0] icw4;
    logic       init_busy;
    logic       init_done;

    modport master (
        input  int_in, int_enable, data_in, wr_req, wr_a0, wr_data,
               vector_ready, init_start, icw1, icw2, icw3, icw4,
        output inta_n, cs_n, wr_n, a0, data_out, data_oe, wr_ack,
               vector_out, vector_valid, init_busy, init_done
    );

    modport slave (
        output int_in, int_enable, data_in, wr_req, wr_a0, wr_data,
               vector_ready, init_start, icw1, icw2, icw3, icw4,
        input  inta_n, cs_n, wr_n, a0, data_out, data_oe, wr_ack,
               vector_out, vector_valid, init_busy, init_done
    );
endinterface
`default_nettype wire

// File: rtl/pic_sync2.sv
`default_nettype none
// ============================================================================
// Module      : pic_sync2
// Description : Two-flop synchronizer, asynchronous active-high reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;
endmodule
`default_nettype wire

// File: rtl/pic_inta_master.sv
`default_nettype none
// ============================================================================
// Module      : pic_inta_master
// Description : Runs the two-pulse INTA acknowledge, captures the vector and
//               performs CS/WR bus writes. Macro PIC_INIT_SEQ_EN adds an
//               automatic ICW1..ICW4 init sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_inta_master
    import pic_host_pkg::*;
#(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2,
    parameter int WR_LOW_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              reset,
    pic_inta_master_if.master bus
);
    localparam int c_CNT_W = 8;
    localparam logic [c_CNT_W-1:0] c_INTA_LOAD = c_CNT_W'(INTA_LOW_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'(INTA_GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LOAD   = c_CNT_W'(WR_LOW_CYCLES - 1);

    pic_state_t         r_state, w_state_next;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_next;
    logic               w_int_s, w_load_wr, w_init_busy, w_wr_a0_sel;
    logic [7:0]         w_wr_data_sel;
    logic               w_inta_n, w_cs_n, w_data_oe, w_wr_ack, w_vector_valid, w_capture;
    logic               r_inta_n, r_cs_n, r_wr_n, r_a0, r_data_oe, r_wr_ack;
    logic               r_vector_valid, r_capture;
    logic [7:0]         r_data_out, r_vector_out;

    pic_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.int_in),
        .q     (w_int_s)
    );

`ifdef PIC_INIT_SEQ_EN
    logic [1:0] r_icw_idx;
    logic       r_init_busy;
    logic       r_init_done;
    logic [2:0] w_icw_step;

    assign w_icw_step = icw_next(r_icw_idx, bus.icw1[ICW1_IC4], bus.icw1[ICW1_SNGL]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_icw_idx   <= 2'd0;
            r_init_busy <= 1'b0;
            r_init_done <= 1'b0;
        end else if (r_state == IDLE && !r_init_busy && bus.init_start) begin
            r_icw_idx   <= 2'd0;
            r_init_busy <= 1'b1;
            r_init_done <= 1'b0;
        end else if (r_state == INIT_NEXT) begin
            r_icw_idx   <= w_icw_step[1:0];
            r_init_busy <= !w_icw_step[2];
            r_init_done <= w_icw_step[2];
        end
    end

    always_comb begin
        w_wr_data_sel = bus.wr_data;
        w_wr_a0_sel   = bus.wr_a0;
        if (r_init_busy) begin
            case (r_icw_idx)
                2'd0:    begin w_wr_data_sel = bus.icw1; w_wr_a0_sel = A0_ICW1_OCW23; end
                2'd1:    begin w_wr_data_sel = bus.icw2; w_wr_a0_sel = A0_ICWn_OCW1;  end
                2'd2:    begin w_wr_data_sel = bus.icw3; w_wr_a0_sel = A0_ICWn_OCW1;  end
                default: begin w_wr_data_sel = bus.icw4; w_wr_a0_sel = A0_ICWn_OCW1;  end
            endcase
        end
    end

    assign w_init_busy   = r_init_busy;
    assign bus.init_busy = r_init_busy;
    assign bus.init_done = r_init_done;
`else
    logic w_unused;
    assign w_unused      = ^{bus.init_start, bus.icw1, bus.icw2, bus.icw3, bus.icw4};
    assign w_init_busy   = 1'b0;
    assign w_wr_data_sel = bus.wr_data;
    assign w_wr_a0_sel   = bus.wr_a0;
    assign bus.init_busy = 1'b0;
    assign bus.init_done = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // r_wr_ack blocks the still-held wr_req from restarting a write on the ack cycle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
        w_load_wr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_init_busy) begin
                    w_state_next = WR_LO;
                    w_cnt_next   = c_WR_LOAD;
                    w_load_wr    = 1'b1;
                end else if (w_int_s && bus.int_enable) begin
                    w_state_next = ACK1;
                    w_cnt_next   = c_INTA_LOAD;
                end else if (bus.wr_req && !r_wr_ack) begin
                    w_state_next = WR_LO;
                    w_cnt_next   = c_WR_LOAD;
                    w_load_wr    = 1'b1;
                end
            end
            ACK1: if (r_cnt == '0) begin
                w_state_next = GAP;
                w_cnt_next   = c_GAP_LOAD;
            end
            GAP: if (r_cnt == '0) begin
                w_state_next = ACK2;
                w_cnt_next   = c_INTA_LOAD;
            end
            ACK2:  if (r_cnt == '0) w_state_next = HOLD;
            HOLD:  if (r_vector_valid && bus.vector_ready) w_state_next = IDLE;
            WR_LO: if (r_cnt == '0) w_state_next = WR_END;
`ifdef PIC_INIT_SEQ_EN
            WR_END:    w_state_next = w_init_busy ? INIT_NEXT : IDLE;
            INIT_NEXT: w_state_next = IDLE;
`else
            WR_END:    w_state_next = IDLE;
`endif
            default:   w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_inta_n       = !(r_state == ACK1 || r_state == ACK2);
        w_cs_n         = (r_state != WR_LO);
        w_data_oe      = (r_state == WR_LO || r_state == WR_END);
        w_wr_ack       = (r_state == WR_END);
        w_vector_valid = (r_state == HOLD) && !(r_vector_valid && bus.vector_ready);
        w_capture      = (r_state == ACK2) && (r_cnt == '0);
    end

    // Registered outputs lag the state by one clock; r_capture lands in the last inta_n-low cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inta_n       <= 1'b1;
            r_cs_n         <= 1'b1;
            r_wr_n         <= 1'b1;
            r_a0           <= 1'b0;
            r_data_out     <= 8'h00;
            r_data_oe      <= 1'b0;
            r_wr_ack       <= 1'b0;
            r_vector_valid <= 1'b0;
            r_vector_out   <= 8'h00;
            r_capture      <= 1'b0;
        end else begin
            r_inta_n       <= w_inta_n;
            r_cs_n         <= w_cs_n;
            r_wr_n         <= w_cs_n;
            r_data_oe      <= w_data_oe;
            r_wr_ack       <= w_wr_ack;
            r_vector_valid <= w_vector_valid;
            r_capture      <= w_capture;
            if (r_capture) r_vector_out <= bus.data_in;
            if (w_load_wr) begin
                r_a0       <= w_wr_a0_sel;
                r_data_out <= w_wr_data_sel;
            end
        end
    end

    assign bus.inta_n       = r_inta_n;
    assign bus.cs_n         = r_cs_n;
    assign bus.wr_n         = r_wr_n;
    assign bus.a0           = r_a0;
    assign bus.data_out     = r_data_out;
    assign bus.data_oe      = r_data_oe;
    assign bus.wr_ack       = r_wr_ack;
    assign bus.vector_valid = r_vector_valid;
    assign bus.vector_out   = r_vector_out;
endmodule
`default_nettype wire

// File: tb/tb_pic_inta_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_inta_master
// Description : Directed self-checking bench for pic_inta_master with a small
//               PIC model driving the vector on every second INTA pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_inta_master;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    int         n_pass = 0;
    int         n_total = 0;
    int         inta_pulses = 0;
    logic [7:0] pic_vec = 8'h00;

    pic_inta_master_if bus ();

    pic_inta_master #(
        .INTA_LOW_CYCLES (2),
        .INTA_GAP_CYCLES (2),
        .WR_LOW_CYCLES   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge bus.inta_n) inta_pulses++;
    assign bus.data_in = (!bus.inta_n && inta_pulses != 0 && inta_pulses[0] == 1'b0) ? pic_vec : 8'h00;

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (bus.inta_n !== 1'b1) $display("FAIL reset_inta_n got %b want 1", bus.inta_n); else n_pass++;
        n_total++; if (bus.cs_n !== 1'b1) $display("FAIL reset_cs_n got %b want 1", bus.cs_n); else n_pass++;
        n_total++; if (bus.wr_n !== 1'b1) $display("FAIL reset_wr_n got %b want 1", bus.wr_n); else n_pass++;
        n_total++; if (bus.a0 !== 1'b0) $display("FAIL reset_a0 got %b want 0", bus.a0); else n_pass++;
        n_total++; if (bus.data_out !== 8'h00) $display("FAIL reset_data_out got %h want 00", bus.data_out); else n_pass++;
        n_total++; if (bus.data_oe !== 1'b0) $display("FAIL reset_data_oe got %b want 0", bus.data_oe); else n_pass++;
        n_total++; if (bus.vector_out !== 8'h00) $display("FAIL reset_vector_out got %h want 00", bus.vector_out); else n_pass++;
        n_total++; if (bus.vector_valid !== 1'b0) $display("FAIL reset_vector_valid got %b want 0", bus.vector_valid); else n_pass++;
        n_total++; if (bus.wr_ack !== 1'b0) $display("FAIL reset_wr_ack got %b want 0", bus.wr_ack); else n_pass++;
        n_total++; if (bus.init_busy !== 1'b0) $display("FAIL reset_init_busy got %b want 0", bus.init_busy); else n_pass++;
`ifdef PIC_INIT_SEQ_EN
        n_total++; if (bus.init_done !== 1'b0) $display("FAIL reset_init_done got %b want 0", bus.init_done); else n_pass++;
`else
        n_total++; if (bus.init_done !== 1'b1) $display("FAIL reset_init_done got %b want 1", bus.init_done); else n_pass++;
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (bus.inta_n !== 1'b1) $display("FAIL idle_inta_n got %b want 1", bus.inta_n); else n_pass++;
    endtask

    task automatic test_inta_basic();
        logic [19:0] obs_inta = '0;
        logic [19:0] obs_vv = '0;
        logic [7:0]  vec_at_valid = 8'h00;
        pic_vec = 8'h48; bus.vector_ready = 1'b1; bus.int_enable = 1'b1; bus.int_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            obs_inta[i] = bus.inta_n;
            obs_vv[i]   = bus.vector_valid;
            if (bus.vector_valid) vec_at_valid = bus.vector_out;
            if (!bus.inta_n) bus.int_in = 1'b0;
        end
        n_total++; if (obs_inta !== 20'hFFE67) $display("FAIL basic_inta_pattern got %h want FFE67", obs_inta); else n_pass++;
        n_total++; if (obs_vv !== 20'h00200) $display("FAIL basic_valid_pattern got %h want 00200", obs_vv); else n_pass++;
        n_total++; if (vec_at_valid !== 8'h48) $display("FAIL basic_vector got %h want 48", vec_at_valid); else n_pass++;
        n_total++; if (bus.vector_out !== 8'h48) $display("FAIL basic_vector_after got %h want 48", bus.vector_out); else n_pass++;
    endtask

    task automatic test_ready_stall();
        logic [19:0] obs_inta = '0;
        logic [19:0] obs_vv = '0;
        int          bad_vec = 0;
        pic_vec = 8'h5A; bus.vector_ready = 1'b0; bus.int_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            obs_inta[i] = bus.inta_n;
            obs_vv[i]   = bus.vector_valid;
            if (bus.vector_valid && bus.vector_out !== 8'h5A) bad_vec++;
            if (!bus.inta_n) bus.int_in = 1'b0;
            if (i == 13) bus.vector_ready = 1'b1;
        end
        n_total++; if (obs_inta !== 20'hFFE67) $display("FAIL stall_inta_pattern got %h want FFE67", obs_inta); else n_pass++;
        n_total++; if (obs_vv !== 20'h03E00) $display("FAIL stall_valid_pattern got %h want 03E00", obs_vv); else n_pass++;
        n_total++; if (bad_vec !== 0) $display("FAIL stall_vector_stable got %0d bad cycles want 0", bad_vec); else n_pass++;
        n_total++; if (bus.vector_out !== 8'h5A) $display("FAIL stall_vector got %h want 5A", bus.vector_out); else n_pass++;
    endtask

    task automatic test_write(input logic a0_v, input logic [7:0] data_v);
        logic [11:0] obs_cs = '0;
        logic [11:0] obs_wr = '0;
        logic [11:0] obs_oe = '0;
        logic [11:0] obs_ack = '0;
        logic        a0_seen = 1'b0;
        logic [7:0]  data_seen = 8'h00;
        bus.wr_req = 1'b1; bus.wr_a0 = a0_v; bus.wr_data = data_v;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            obs_cs[i] = bus.cs_n; obs_wr[i] = bus.wr_n; obs_oe[i] = bus.data_oe; obs_ack[i] = bus.wr_ack;
            if (i == 1) begin a0_seen = bus.a0; data_seen = bus.data_out; end
            if (bus.wr_ack) bus.wr_req = 1'b0;
        end
        bus.wr_req = 1'b0;
        n_total++; if (obs_cs !== 12'hFF9) $display("FAIL write_cs_pattern got %h want FF9", obs_cs); else n_pass++;
        n_total++; if (obs_wr !== 12'hFF9) $display("FAIL write_wr_pattern got %h want FF9", obs_wr); else n_pass++;
        n_total++; if (obs_oe !== 12'h00E) $display("FAIL write_oe_pattern got %h want 00E", obs_oe); else n_pass++;
        n_total++; if (obs_ack !== 12'h008) $display("FAIL write_ack_pattern got %h want 008", obs_ack); else n_pass++;
        n_total++; if (a0_seen !== a0_v) $display("FAIL write_a0 got %b want %b", a0_seen, a0_v); else n_pass++;
        n_total++; if (data_seen !== data_v) $display("FAIL write_data got %h want %h", data_seen, data_v); else n_pass++;
    endtask

    task automatic test_reset_in_gap();
        logic [19:0] obs_inta = '0;
        logic [7:0]  vec_at_valid = 8'h00;
        int          lows = 0;
        pic_vec = 8'h33; bus.vector_ready = 1'b1; bus.int_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!bus.inta_n) lows++;
        end
        n_total++; if (lows !== 2) $display("FAIL gap_first_pulse got %0d low cycles want 2", lows); else n_pass++;
        reset = 1'b1;
        #1;
        inta_pulses = 0;
        n_total++; if (bus.inta_n !== 1'b1) $display("FAIL gap_reset_inta_n got %b want 1", bus.inta_n); else n_pass++;
        n_total++; if (bus.vector_valid !== 1'b0) $display("FAIL gap_reset_valid got %b want 0", bus.vector_valid); else n_pass++;
        n_total++; if (bus.vector_out !== 8'h00) $display("FAIL gap_reset_vector got %h want 00", bus.vector_out); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            obs_inta[i] = bus.inta_n;
            if (bus.vector_valid) vec_at_valid = bus.vector_out;
            if (!bus.inta_n) bus.int_in = 1'b0;
        end
        n_total++; if (obs_inta !== 20'hFFE67) $display("FAIL gap_restart_pattern got %h want FFE67", obs_inta); else n_pass++;
        n_total++; if (vec_at_valid !== 8'h33) $display("FAIL gap_restart_vector got %h want 33", vec_at_valid); else n_pass++;
    endtask

    task automatic test_int_enable();
        int   lows = 0;
        logic s0;
        logic s1;
        pic_vec = 8'h11; bus.vector_ready = 1'b1; bus.int_enable = 1'b0; bus.int_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.inta_n) lows++;
        end
        n_total++; if (lows !== 0) $display("FAIL disabled_inta got %0d low cycles want 0", lows); else n_pass++;
        bus.int_enable = 1'b1;
        @(negedge clk); s0 = bus.inta_n;
        @(negedge clk); s1 = bus.inta_n;
        bus.int_in = 1'b0;
        n_total++; if ({s0, s1} !== 2'b10) $display("FAIL enable_start got %b want 10", {s0, s1}); else n_pass++;
        repeat (12) @(negedge clk);
        n_total++; if (bus.vector_out !== 8'h11) $display("FAIL enable_vector got %h want 11", bus.vector_out); else n_pass++;
    endtask

    task automatic test_init();
`ifdef PIC_INIT_SEQ_EN
        logic [8:0] wr_log [4];
        int         n_wr = 0;
        int         busy_inta = 0;
        logic       prev_cs = 1'b1;
        for (int j = 0; j < 4; j++) wr_log[j] = '0;
        bus.icw1 = 8'h13; bus.icw2 = 8'h20; bus.icw3 = 8'hAA; bus.icw4 = 8'h01;
        pic_vec = 8'h77; bus.vector_ready = 1'b1; bus.int_enable = 1'b1;
        bus.init_start = 1'b1; bus.int_in = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (i == 0) bus.init_start = 1'b0;
            if (!bus.cs_n && prev_cs) begin
                if (n_wr < 4) wr_log[n_wr] = {bus.a0, bus.data_out};
                n_wr++;
            end
            prev_cs = bus.cs_n;
            if (!bus.inta_n && bus.init_busy) busy_inta++;
            if (!bus.inta_n) bus.int_in = 1'b0;
        end
        n_total++; if (n_wr !== 3) $display("FAIL init_write_count got %0d want 3", n_wr); else n_pass++;
        n_total++; if (wr_log[0] !== 9'h013) $display("FAIL init_icw1 got %h want 013", wr_log[0]); else n_pass++;
        n_total++; if (wr_log[1] !== 9'h120) $display("FAIL init_icw2 got %h want 120", wr_log[1]); else n_pass++;
        n_total++; if (wr_log[2] !== 9'h101) $display("FAIL init_icw4 got %h want 101", wr_log[2]); else n_pass++;
        n_total++; if (busy_inta !== 0) $display("FAIL init_int_blocked got %0d want 0", busy_inta); else n_pass++;
        n_total++; if (bus.init_done !== 1'b1) $display("FAIL init_done got %b want 1", bus.init_done); else n_pass++;
        n_total++; if (bus.init_busy !== 1'b0) $display("FAIL init_busy_end got %b want 0", bus.init_busy); else n_pass++;
        n_total++; if (bus.vector_out !== 8'h77) $display("FAIL init_then_vector got %h want 77", bus.vector_out); else n_pass++;
`else
        int cs_lows = 0;
        bus.icw1 = 8'h13; bus.init_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.init_start = 1'b0;
            if (!bus.cs_n) cs_lows++;
        end
        n_total++; if (cs_lows !== 0) $display("FAIL noinit_writes got %0d want 0", cs_lows); else n_pass++;
        n_total++; if (bus.init_done !== 1'b1) $display("FAIL noinit_done got %b want 1", bus.init_done); else n_pass++;
`endif
    endtask

    initial begin
        bus.int_in = 1'b0; bus.int_enable = 1'b0; bus.wr_req = 1'b0; bus.wr_a0 = 1'b0;
        bus.wr_data = 8'h00; bus.vector_ready = 1'b0; bus.init_start = 1'b0;
        bus.icw1 = 8'h00; bus.icw2 = 8'h00; bus.icw3 = 8'h00; bus.icw4 = 8'h00;
        test_reset();
        test_inta_basic();
        test_ready_stall();
        test_write(1'b1, 8'hFB);
        test_write(1'b0, 8'h0C);
        test_reset_in_gap();
        test_int_enable();
        test_init();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
